// File: rtl/pool_job_sched.sv
// Round-robin job scheduler that shares one pool2d_unit between NUM_REQ requesters.
// It validates each job descriptor, runs the job under a watchdog and returns a completion record.
module pool_job_sched #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned BUS_W       = 128,
    parameter int unsigned LINE_BEATS  = 256,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*73-1:0]  req_desc_i,
    output logic                   cpl_valid_o,
    input  logic                   cpl_ready_i,
    output logic [2:0]             cpl_id_o,
    output logic [1:0]             cpl_status_o,
    output logic [7:0]             pool_cfg_elem_bits_o,
    output logic                   pool_cfg_pool_kind_o,
    output logic [7:0]             pool_cfg_ksize_o,
    output logic [7:0]             pool_cfg_stride_o,
    output logic [15:0]            pool_cfg_h_in_o,
    output logic [15:0]            pool_cfg_w_in_o,
    output logic [15:0]            pool_cfg_c_o,
    output logic                   pool_start_o,
    input  logic                   pool_busy_i,
    input  logic                   pool_done_i,
    output logic                   sched_busy_o,
    output logic [7:0]             timeout_cnt_o
);

    localparam int unsigned DescW = 73;
    localparam int unsigned WdW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [37:0] LineCap = 38'(LINE_BEATS * BUS_W);

    localparam logic [1:0] StatOk      = 2'd0;
    localparam logic [1:0] StatCfgErr  = 2'd1;
    localparam logic [1:0] StatTimeout = 2'd2;

    typedef enum logic [2:0] {StIdle, StCheck, StStart, StRun, StCpl} state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       id_q, id_d;
    logic [1:0]       status_q, status_d;
    logic [DescW-1:0] cfg_q, cfg_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [7:0]       tcnt_q, tcnt_d;

    logic [DescW-1:0] desc_arr [8];
    logic [7:0]       req_pad;
    logic [7:0]       grant_oh;
    logic [2:0]       grant_idx;
    logic [2:0]       cand;
    logic             grant_found;
    logic             grant;
    logic [37:0]      line_bits;
    logic             elem_ok;
    logic             cfg_valid;

    for (genvar i = 0; i < 8; i++) begin : g_desc
        if (i < NUM_REQ) begin : g_used
            assign desc_arr[i] = req_desc_i[i*DescW +: DescW];
        end else begin : g_unused
            assign desc_arr[i] = '0;
        end
    end

    assign req_pad = 8'(req_valid_i);

    // Round-robin search begins at ptr_q, the requester after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 3'((32'(ptr_q) + off) % NUM_REQ);
            if (!grant_found && req_pad[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant       = (state_q == StIdle) && grant_found && !pool_busy_i;
    assign grant_oh    = grant ? (8'd1 << grant_idx) : 8'd0;
    assign req_ready_o = grant_oh[NUM_REQ-1:0];

    assign pool_cfg_elem_bits_o = cfg_q[72:65];
    assign pool_cfg_pool_kind_o = cfg_q[64];
    assign pool_cfg_ksize_o     = cfg_q[63:56];
    assign pool_cfg_stride_o    = cfg_q[55:48];
    assign pool_cfg_h_in_o      = cfg_q[47:32];
    assign pool_cfg_w_in_o      = cfg_q[31:16];
    assign pool_cfg_c_o         = cfg_q[15:0];

    // ceil(bits/BUS_W) <= LINE_BEATS is equivalent to bits <= LINE_BEATS*BUS_W.
    assign line_bits = 38'(pool_cfg_w_in_o) * 38'(pool_cfg_c_o) * 38'(pool_cfg_elem_bits_o[5:0]);
    assign elem_ok   = pool_cfg_elem_bits_o inside {8'd2, 8'd4, 8'd8, 8'd16, 8'd32};
    assign cfg_valid = elem_ok && (pool_cfg_ksize_o == 8'd2) && (pool_cfg_stride_o == 8'd2) &&
                       (pool_cfg_h_in_o >= 16'd2) && (pool_cfg_w_in_o >= 16'd2) &&
                       (pool_cfg_c_o != 16'd0) && (line_bits <= LineCap);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        status_d = status_q;
        cfg_d    = cfg_q;
        wd_d     = wd_q;
        tcnt_d   = tcnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    cfg_d   = desc_arr[grant_idx];
                    id_d    = grant_idx;
                    ptr_d   = 3'((32'(grant_idx) + 1) % NUM_REQ);
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (cfg_valid) begin
                    state_d = StStart;
                end else begin
                    status_d = StatCfgErr;
                    state_d  = StCpl;
                end
            end
            StStart: begin
                wd_d    = '0;
                state_d = StRun;
            end
            StRun: begin
                wd_d = wd_q + WdW'(1);
                if (pool_done_i) begin
                    status_d = StatOk;
                    state_d  = StCpl;
                end else if (32'(wd_q) + 1 >= TIMEOUT_CYC) begin
                    status_d = StatTimeout;
                    state_d  = StCpl;
                    if (tcnt_q != 8'hff) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            StCpl: begin
                if (cpl_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            id_q     <= '0;
            status_q <= '0;
            cfg_q    <= '0;
            wd_q     <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            status_q <= status_d;
            cfg_q    <= cfg_d;
            wd_q     <= wd_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign cpl_valid_o   = (state_q == StCpl);
    assign cpl_id_o      = id_q;
    assign cpl_status_o  = status_q;
    assign pool_start_o  = (state_q == StStart);
    assign sched_busy_o  = (state_q != StIdle);
    assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_pool_job_sched.sv
// Bench for pool_job_sched: a cycle-level job-timeline model checked every cycle,
// plus directed jobs with hand-computed latencies and statuses.
module tb_pool_job_sched;
    localparam int N  = 2;
    localparam int TO = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*73-1:0] req_desc = '0;
    logic           cpl_valid, cpl_ready = 1'b1;
    logic [2:0]     cpl_id;
    logic [1:0]     cpl_status;
    logic [7:0]     c_elem, c_ks, c_st;
    logic           c_kind;
    logic [15:0]    c_h, c_w, c_c;
    logic           pool_start, sched_busy;
    logic           pool_busy = 1'b0, pool_done = 1'b0;
    logic [7:0]     timeout_cnt;

    always #5 clk = ~clk;

    pool_job_sched #(.NUM_REQ(N), .BUS_W(128), .LINE_BEATS(256), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_desc_i(req_desc), .cpl_valid_o(cpl_valid), .cpl_ready_i(cpl_ready),
        .cpl_id_o(cpl_id), .cpl_status_o(cpl_status), .pool_cfg_elem_bits_o(c_elem),
        .pool_cfg_pool_kind_o(c_kind), .pool_cfg_ksize_o(c_ks), .pool_cfg_stride_o(c_st),
        .pool_cfg_h_in_o(c_h), .pool_cfg_w_in_o(c_w), .pool_cfg_c_o(c_c),
        .pool_start_o(pool_start), .pool_busy_i(pool_busy), .pool_done_i(pool_done),
        .sched_busy_o(sched_busy), .timeout_cnt_o(timeout_cnt)
    );

    int total = 0, bad = 0, cyc = 0;

    task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [72:0] mk(int e, int k, int ks, int st, int h, int w, int c);
        return {8'(e), 1'(k), 8'(ks), 8'(st), 16'(h), 16'(w), 16'(c)};
    endfunction

    function automatic bit desc_ok(logic [72:0] d);
        longint e = d[72:65], ks = d[63:56], st = d[55:48];
        longint h = d[47:32], w = d[31:16], c = d[15:0];
        bit e_ok = (e == 2) || (e == 4) || (e == 8) || (e == 16) || (e == 32);
        return e_ok && ks == 2 && st == 2 && h >= 2 && w >= 2 && c >= 1 &&
               ((w * c * e + 127) / 128) <= 256;
    endfunction

    // Pool unit model: done_delay cycles after start (0 = never), busy until done or release.
    int done_delay = 10;
    int done_at = -1;
    bit pb_on = 0, pb_release = 0;
    always @(negedge clk) begin
        if (rst) begin
            pb_on = 0; done_at = -1; pb_release = 0;
        end else begin
            if (pool_done) pb_on = 0;
            if (pb_release) begin pb_on = 0; pb_release = 0; end
            if (pool_start) begin
                pb_on = 1;
                done_at = (done_delay > 0) ? cyc + done_delay : -1;
            end
        end
    end
    always @(posedge clk) begin
        cyc++;
        #1;
        pool_done = (cyc == done_at);
        pool_busy = pb_on;
    end

    // Job-timeline model: m_since counts cycles since the grant cycle.
    bit m_busy = 0, m_cpl = 0, m_ok = 0;
    int m_since = 0, m_id = 0, m_stat = 0, m_ptr = 0, m_tcnt = 0;
    logic [72:0] m_cfg = '0;
    int gr_log[$];
    int cpl_ids[$], cpl_sts[$];
    int gr_cyc = 0, st_cyc = 0, n_start = 0, cv_rise = 0, n_cv = 0, viol = 0;
    bit prev_cv = 0;

    function automatic int pick();
        if (rst || m_busy || pool_busy) return -1;
        for (int off = 0; off < N; off++)
            if (req_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        if (rst) begin
            m_busy = 0; m_cpl = 0; m_ptr = 0; m_tcnt = 0; m_cfg = '0; m_stat = 0; m_id = 0;
        end
        g = pick();
        chk("req_ready", 73'(req_ready), (g >= 0) ? 73'(1 << g) : 73'(0));
        chk("sched_busy", 73'(sched_busy), 73'(m_busy));
        chk("pool_start", 73'(pool_start), 73'(m_busy && !m_cpl && m_ok && m_since == 2));
        chk("cpl_valid", 73'(cpl_valid), 73'(m_cpl));
        if (m_cpl) begin
            chk("cpl_id", 73'(cpl_id), 73'(m_id));
            chk("cpl_status", 73'(cpl_status), 73'(m_stat));
        end
        chk("timeout_cnt", 73'(timeout_cnt), 73'(m_tcnt));
        chk("pool_cfg", {c_elem, c_kind, c_ks, c_st, c_h, c_w, c_c}, m_cfg);
        for (int i = 0; i < N; i++) if (req_ready[i]) begin gr_log.push_back(i); gr_cyc = cyc; end
        if (|req_ready && sched_busy) viol++;
        if (pool_start) begin n_start++; st_cyc = cyc; end
        if (cpl_valid && !prev_cv) begin cv_rise = cyc; n_cv++; end
        prev_cv = cpl_valid;
        if (cpl_valid && cpl_ready) begin cpl_ids.push_back(cpl_id); cpl_sts.push_back(cpl_status); end
        if (!rst) begin
            if (!m_busy) begin
                if (g >= 0) begin
                    m_busy = 1; m_cpl = 0; m_id = g; m_since = 1;
                    m_cfg = req_desc[g*73 +: 73]; m_ok = desc_ok(m_cfg); m_ptr = (g + 1) % N;
                end
            end else if (m_cpl) begin
                if (cpl_ready) begin m_busy = 0; m_cpl = 0; end
            end else if (!m_ok) begin
                m_cpl = 1; m_stat = 1;
            end else if (m_since >= 3) begin
                if (pool_done) begin m_cpl = 1; m_stat = 0; end
                else if (m_since - 2 == TO) begin
                    m_cpl = 1; m_stat = 2;
                    if (m_tcnt < 255) m_tcnt++;
                end else m_since++;
            end else m_since++;
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input string nm, input int cur, input int target, input int which);
        int k = 0;
        while (k < 200) begin
            cur = (which == 0) ? gr_log.size() : (which == 1) ? cpl_ids.size() : n_cv;
            if (cur >= target) break;
            step(); k++;
        end
        if (cur < target) begin
            total++; bad++;
            $display("FAIL %s: got count %0d required %0d within 200 cycles", nm, cur, target);
        end
    endtask

    task automatic do_reset();
        rst = 1; req_valid = '0; cpl_ready = 1;
        step(2);
        rst = 0;
        step();
    endtask

    task automatic issue(input int id, input logic [72:0] d);
        req_desc[id*73 +: 73] = d;
        req_valid[id] = 1'b1;
        wait_until("grant", 0, gr_log.size() + 1, 0);
        req_valid[id] = 1'b0;
    endtask

    task automatic job(input int id, input logic [72:0] d, input int exp_stat);
        int n0 = cpl_ids.size();
        issue(id, d);
        wait_until("cpl", 0, n0 + 1, 1);
        if (cpl_ids.size() > n0) chk("job_status", 73'(cpl_sts[n0]), 73'(exp_stat));
    endtask

    initial begin
        int t, s0, n0, g0;
        // 1) single valid job, done 10 cycles after start
        do_reset();
        done_delay = 10;
        job(0, mk(8, 1, 2, 2, 4, 4, 16), 0);
        t = gr_cyc;
        chk("t1_starts", 73'(n_start), 73'(1));
        chk("t1_start_cyc", 73'(st_cyc), 73'(t + 2));
        chk("t1_cpl_cyc", 73'(cv_rise), 73'(t + 13));
        chk("t1_cpl_id", 73'(cpl_ids[$]), 73'(0));
        // 2) both requesters held valid for 4 jobs
        do_reset();
        done_delay = 3;
        g0 = gr_log.size();
        req_desc = {mk(16, 0, 2, 2, 8, 8, 4), mk(8, 1, 2, 2, 4, 4, 16)};
        req_valid = 2'b11;
        wait_until("t2_grants", 0, g0 + 4, 0);
        req_valid = '0;
        step(20);
        chk("t2_g0", 73'(gr_log[g0]), 73'(0));
        chk("t2_g1", 73'(gr_log[g0 + 1]), 73'(1));
        chk("t2_g2", 73'(gr_log[g0 + 2]), 73'(0));
        chk("t2_g3", 73'(gr_log[g0 + 3]), 73'(1));
        chk("t2_ready_busy", 73'(viol), 73'(0));
        // 3) config errors never start the pool
        s0 = n_start;
        job(0, mk(8, 1, 3, 2, 4, 4, 16), 1);
        job(0, mk(6, 1, 2, 2, 4, 4, 16), 1);
        job(0, mk(8, 1, 2, 2, 4, 1, 16), 1);
        chk("t3_no_start", 73'(n_start), 73'(s0));
        // 4) line-capacity boundary
        job(0, mk(32, 0, 2, 2, 2, 1024, 1), 0);
        job(0, mk(32, 0, 2, 2, 2, 1028, 1), 1);
        // 5) watchdog timeout, then no grant while pool still busy
        do_reset();
        done_delay = 0;
        job(0, mk(8, 1, 2, 2, 4, 4, 16), 2);
        t = gr_cyc;
        chk("t5_cpl_cyc", 73'(cv_rise), 73'(t + 3 + TO));
        chk("t5_tcnt", 73'(timeout_cnt), 73'(1));
        n0 = gr_log.size();
        req_desc[73 +: 73] = mk(4, 0, 2, 2, 6, 6, 2);
        req_valid[1] = 1'b1;
        step(6);
        chk("t5_no_grant", 73'(gr_log.size()), 73'(n0));
        done_delay = 3;
        pb_release = 1;
        wait_until("t5_grant", 0, n0 + 1, 0);
        req_valid[1] = 1'b0;
        chk("t5_grant_id", 73'(gr_log[n0]), 73'(1));
        n0 = cpl_ids.size();
        wait_until("t5_cpl", 0, n0 + 1, 1);
        // 6) completion back-pressure, then reset mid-run
        done_delay = 4;
        cpl_ready = 0;
        n0 = n_cv;
        issue(0, mk(2, 1, 2, 2, 3, 16, 3));
        wait_until("t6_cv", 0, n0 + 1, 2);
        step(5);
        chk("t6_hold_valid", 73'(cpl_valid), 73'(1));
        chk("t6_hold_id", 73'(cpl_id), 73'(0));
        chk("t6_hold_status", 73'(cpl_status), 73'(0));
        cpl_ready = 1;
        step(2);
        done_delay = 0;
        n0 = cpl_ids.size();
        issue(0, mk(8, 1, 2, 2, 4, 4, 16));
        step(5);
        rst = 1;
        #2;
        chk("t6_rst_busy", 73'(sched_busy), 73'(0));
        chk("t6_rst_cplv", 73'(cpl_valid), 73'(0));
        chk("t6_rst_tcnt", 73'(timeout_cnt), 73'(0));
        chk("t6_rst_cfg", {c_elem, c_kind, c_ks, c_st, c_h, c_w, c_c}, 73'(0));
        step(2);
        rst = 0;
        step(30);
        chk("t6_no_cpl", 73'(cpl_ids.size()), 73'(n0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
        $fatal(1);
    end
endmodule
